pwm_duty_ramp: RTL and testbench

- Slew-limited duty-cycle source sitting directly upstream of the 8-bit PWM generator; its duty_cycle output drives the generator's duty_cycle input.
- Accepts a target duty over a valid/ready handshake and moves the applied duty toward it by at most `step` per PWM period.
- Updates land only on period boundaries, so the generator never sees a mid-period duty change.
- Provides soft-start on enable and soft-stop (ramp to 0) on disable.

---
 rtl/pwm_duty_ramp.sv | 137 +++++++++++++
 tb/tb_pwm_duty_ramp.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// Slew-limited duty source for an 8-bit PWM generator. Moves the applied duty toward
// a handshaked target by at most `step` per PWM period, updating only on period boundaries.
module pwm_duty_ramp #(
  parameter int WIDTH  = 8,
  parameter int PERIOD = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_duty,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] duty_cycle,
  output logic             period_tick,
  output logic             busy,
  output logic             at_target
);

  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_HOLD,
    S_RAMP,
    S_STOP
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             tick_reg, tick_next;
  logic [WIDTH-1:0] duty_reg, duty_next;
  logic [WIDTH-1:0] target_reg, target_next;

  // Step arithmetic working signals (one extra bit so nothing wraps).
  logic [WIDTH-1:0] eff_tgt;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH:0]   tgt_w;
  logic [WIDTH-1:0] stepped;

  // Free-running period counter; the tick is registered so it lines up with cnt == LAST.
  always_comb begin
    cnt_next  = (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
    tick_next = (cnt_next == LAST);
  end

  // Target register: cleared whenever disabled, so a soft-stop always heads for 0.
  always_comb begin
    target_next = target_reg;
    if (!enable) begin
      target_next = '0;
    end else if (tgt_valid) begin
      target_next = tgt_duty;
    end
  end

  // A tick seen with enable low already steps toward 0.
  always_comb begin
    eff_tgt = enable ? target_reg : '0;
    sum_w   = {1'b0, duty_reg} + {1'b0, step};
    diff_w  = {1'b0, duty_reg} - {1'b0, step};
    tgt_w   = {1'b0, eff_tgt};
    stepped = eff_tgt;
    if (step == '0 || duty_reg == eff_tgt) begin
      stepped = eff_tgt;
    end else if (eff_tgt > duty_reg) begin
      stepped = (sum_w >= tgt_w) ? eff_tgt : sum_w[WIDTH-1:0];
    end else begin
      stepped = (diff_w[WIDTH] || diff_w <= tgt_w) ? eff_tgt : diff_w[WIDTH-1:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    duty_next  = duty_reg;
    if (tick_reg) begin
      duty_next = stepped;
      if (enable) begin
        state_next = (stepped == target_reg) ? S_HOLD : S_RAMP;
      end else begin
        state_next = (stepped == '0) ? S_OFF : S_STOP;
      end
    end else begin
      case (state_reg)
        S_OFF: begin
          if (enable) begin
            state_next = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!enable) begin
            state_next = (duty_reg != '0) ? S_STOP : S_OFF;
          end else if (target_reg != duty_reg) begin
            state_next = S_RAMP;
          end
        end
        S_RAMP: begin
          if (!enable) begin
            state_next = S_STOP;
          end
        end
        S_STOP: begin
          if (enable) begin
            state_next = S_RAMP;
          end
        end
        default: state_next = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_OFF;
      cnt_reg    <= '0;
      tick_reg   <= 1'b0;
      duty_reg   <= '0;
      target_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      tick_reg   <= tick_next;
      duty_reg   <= duty_next;
      target_reg <= target_next;
    end
  end

  // Handshake and status outputs are held low while reset is asserted.
  assign tgt_ready   = reset & enable;
  assign duty_cycle  = duty_reg;
  assign period_tick = tick_reg;
  assign busy        = (state_reg == S_RAMP) || (state_reg == S_STOP);
  assign at_target   = reset & enable & (duty_reg == target_reg);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp with PERIOD=8: tick cadence, ramps, retarget,
// soft-stop, tick-cycle acceptance and asynchronous reset.
module tb_pwm_duty_ramp;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [7:0] tgt_duty;
  logic [7:0] step;
  logic [7:0] duty_cycle;
  logic       period_tick;
  logic       busy;
  logic       at_target;

  int n_cmp = 0;
  int n_bad = 0;

  pwm_duty_ramp #(.WIDTH(8), .PERIOD(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .tgt_duty   (tgt_duty),
    .step       (step),
    .duty_cycle (duty_cycle),
    .period_tick(period_tick),
    .busy       (busy),
    .at_target  (at_target)
  );

  always #5 clk = ~clk;

  // Stops at the negedge of the cycle in which period_tick is high.
  task automatic wait_tick_high(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (period_tick === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s: period_tick not seen within 20 clocks", nm);
    end
  endtask

  // Returns at the negedge right after the edge that ends a tick cycle.
  task automatic wait_tick(input string nm);
    wait_tick_high(nm);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic accept(input logic [7:0] t);
    tgt_valid = 1'b1;
    tgt_duty  = t;
    @(posedge clk);
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; tgt_valid = 1'b0; tgt_duty = 8'd0; step = 8'd0;
    #2;
    n_cmp++; if (duty_cycle !== 8'd0) begin n_bad++; $display("FAIL reset_duty: got %0d want 0", duty_cycle); end
    n_cmp++; if (tgt_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", tgt_ready); end
    n_cmp++; if (at_target !== 1'b0) begin n_bad++; $display("FAIL reset_at_target: got %b want 0", at_target); end
    n_cmp++; if (busy !== 1'b0 || period_tick !== 1'b0) begin n_bad++; $display("FAIL reset_busy_tick: got %b%b want 00", busy, period_tick); end
    $display("test_reset: outputs checked in reset");
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_idle();
    reset = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_cmp++;
      if (period_tick !== ((i % 8) == 7)) begin
        n_bad++; $display("FAIL idle_tick clk%0d: got %b want %b", i, period_tick, (i % 8) == 7);
      end
    end
    n_cmp++; if (duty_cycle !== 8'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_state: duty %0d busy %b want 0 0", duty_cycle, busy); end
    $display("test_idle: 40 clocks with enable=0 checked");
  endtask

  task automatic test_ramp_up();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'd30; exp_d[1] = 8'd60; exp_d[2] = 8'd90; exp_d[3] = 8'd100;
    enable = 1'b1; step = 8'd30;
    #1;
    n_cmp++; if (tgt_ready !== 1'b1) begin n_bad++; $display("FAIL ramp_up_ready: got %b want 1", tgt_ready); end
    accept(8'd100);
    for (int i = 0; i < 4; i++) begin
      wait_tick("ramp_up");
      n_cmp++;
      if (duty_cycle !== exp_d[i]) begin n_bad++; $display("FAIL ramp_up_duty%0d: got %0d want %0d", i, duty_cycle, exp_d[i]); end
      $display("ramp_up tick %0d: duty=%0d", i, duty_cycle);
      if (i == 1) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ramp_up_busy: got %b want 1", busy); end
      end
    end
    n_cmp++; if (at_target !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL ramp_up_hold: at_target %b busy %b want 1 0", at_target, busy); end
  endtask

  task automatic test_ramp_down();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'd50; exp_d[1] = 8'd20; exp_d[2] = 8'd20;
    step = 8'd50;
    accept(8'd20);
    for (int i = 0; i < 3; i++) begin
      wait_tick("ramp_down");
      n_cmp++;
      if (duty_cycle !== exp_d[i]) begin n_bad++; $display("FAIL ramp_down_duty%0d: got %0d want %0d", i, duty_cycle, exp_d[i]); end
      $display("ramp_down tick %0d: duty=%0d", i, duty_cycle);
    end
    n_cmp++; if (at_target !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL ramp_down_hold: at_target %b busy %b want 1 0", at_target, busy); end
  endtask

  task automatic test_retarget();
    step = 8'd40;
    accept(8'd200);
    wait_tick("retarget");
    n_cmp++; if (duty_cycle !== 8'd60 || busy !== 1'b1) begin n_bad++; $display("FAIL retarget_mid: duty %0d busy %b want 60 1", duty_cycle, busy); end
    $display("retarget tick 0: duty=%0d", duty_cycle);
    step = 8'd30;
    accept(8'd40);
    wait_tick("retarget");
    n_cmp++; if (duty_cycle !== 8'd40) begin n_bad++; $display("FAIL retarget_duty: got %0d want 40", duty_cycle); end
    n_cmp++; if (at_target !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL retarget_hold: at_target %b busy %b want 1 0", at_target, busy); end
    $display("retarget tick 1: duty=%0d", duty_cycle);
  endtask

  task automatic test_back_to_back();
    step = 8'd0;
    tgt_valid = 1'b1; tgt_duty = 8'd200;
    @(posedge clk); @(negedge clk);
    tgt_duty = 8'd90;
    @(posedge clk); @(negedge clk);
    tgt_valid = 1'b0;
    wait_tick("back_to_back");
    n_cmp++; if (duty_cycle !== 8'd90) begin n_bad++; $display("FAIL back_to_back_duty: got %0d want 90", duty_cycle); end
    $display("back_to_back: duty=%0d", duty_cycle);
  endtask

  task automatic test_stop();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'd50; exp_d[1] = 8'd10; exp_d[2] = 8'd0;
    step = 8'd40; enable = 1'b0; tgt_valid = 1'b1; tgt_duty = 8'd200;
    #1;
    n_cmp++; if (tgt_ready !== 1'b0) begin n_bad++; $display("FAIL stop_ready: got %b want 0", tgt_ready); end
    @(posedge clk); @(negedge clk);
    tgt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_tick("stop");
      n_cmp++;
      if (duty_cycle !== exp_d[i]) begin n_bad++; $display("FAIL stop_duty%0d: got %0d want %0d", i, duty_cycle, exp_d[i]); end
      $display("stop tick %0d: duty=%0d", i, duty_cycle);
      if (i == 0) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stop_busy: got %b want 1", busy); end
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stop_off: busy %b want 0", busy); end
    enable = 1'b1;
    @(posedge clk); @(negedge clk);
    wait_tick("reenable");
    n_cmp++; if (duty_cycle !== 8'd0 || at_target !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reenable_hold: duty %0d at_target %b busy %b want 0 1 0", duty_cycle, at_target, busy);
    end
    $display("reenable: duty=%0d", duty_cycle);
  endtask

  task automatic test_tick_accept();
    step = 8'd0;
    wait_tick_high("tick_accept");
    tgt_valid = 1'b1; tgt_duty = 8'd255;
    @(posedge clk); @(negedge clk);
    tgt_valid = 1'b0;
    n_cmp++; if (duty_cycle !== 8'd0) begin n_bad++; $display("FAIL tick_accept_same: got %0d want 0", duty_cycle); end
    wait_tick("tick_accept");
    n_cmp++; if (duty_cycle !== 8'd255 || at_target !== 1'b1) begin n_bad++; $display("FAIL tick_accept_next: duty %0d at_target %b want 255 1", duty_cycle, at_target); end
    $display("tick_accept: duty=%0d", duty_cycle);
  endtask

  task automatic test_reset_mid();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (duty_cycle !== 8'd0 || busy !== 1'b0 || period_tick !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_out: duty %0d busy %b tick %b want 0 0 0", duty_cycle, busy, period_tick);
    end
    n_cmp++; if (tgt_ready !== 1'b0 || at_target !== 1'b0) begin n_bad++; $display("FAIL reset_mid_hs: ready %b at_target %b want 0 0", tgt_ready, at_target); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 7 || i == 6) begin
        n_cmp++; if (period_tick !== (i == 7)) begin n_bad++; $display("FAIL reset_mid_tick clk%0d: got %b want %b", i, period_tick, i == 7); end
      end
    end
    n_cmp++; if (duty_cycle !== 8'd0 || at_target !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_after: duty %0d at_target %b busy %b want 0 1 0", duty_cycle, at_target, busy);
    end
    $display("reset_mid: duty=%0d after release", duty_cycle);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_ramp_up();
    test_ramp_down();
    test_retarget();
    test_back_to_back();
    test_stop();
    test_tick_accept();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
